// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter_if
//  Description : Bundle of the two writeback request channels, the shared
//                register-file write port and the pending-write probe.
//  Revision    : 1.0  initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // ALU writeback channel
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rw;
    logic [DATA_W-1:0] alu_dw;

    // Load writeback channel
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rw;
    logic [DATA_W-1:0] mem_dw;

    // Register file write port
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] dw;
    logic              rf_wr_en;

    // Hazard probe and status
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_pending;
    logic              busy;

    // Issue / writeback side
    modport master (
        output alu_valid, alu_rw, alu_dw,
        output mem_valid, mem_rw, mem_dw,
        output chk_addr,
        input  alu_ready, mem_ready,
        input  rw, dw, rf_wr_en,
        input  chk_pending, busy
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rw, alu_dw,
        input  mem_valid, mem_rw, mem_dw,
        input  chk_addr,
        output alu_ready, mem_ready,
        output rw, dw, rf_wr_en,
        output chk_pending, busy
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Two-source register-file write port arbiter. Each source
//                owns a small FIFO; a round-robin arbiter drains one head per
//                cycle into a registered write port. A combinational probe
//                reports writes still queued or on the port for an address.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rf_write_arbiter_if.slave     bus
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam int c_ALU   = 0;
    localparam int c_MEM   = 1;

    // Per-source request view, index c_ALU / c_MEM
    logic [1:0]             w_in_valid;
    logic [1:0][ADDR_W-1:0] w_in_rw;
    logic [1:0][DATA_W-1:0] w_in_dw;

    // Per-source FIFO status and heads
    logic [1:0]             w_ready;
    logic [1:0]             w_empty;
    logic [1:0]             w_grant;
    logic [1:0]             w_hit;
    logic [1:0][ADDR_W-1:0] w_head_rw;
    logic [1:0][DATA_W-1:0] w_head_dw;

    // Arbitration history and registered write port
    logic                   r_last_grant;
    logic                   r_rf_wr_en;
    logic [ADDR_W-1:0]      r_rw;
    logic [DATA_W-1:0]      r_dw;

    assign w_in_valid = {bus.mem_valid, bus.alu_valid};
    assign w_in_rw    = {bus.mem_rw,    bus.alu_rw};
    assign w_in_dw    = {bus.mem_dw,    bus.alu_dw};

    assign bus.alu_ready = w_ready[c_ALU];
    assign bus.mem_ready = w_ready[c_MEM];

    // ------------------------------------------------------------------------
    // One FIFO per source. Pointers carry an extra wrap bit so that equal
    // indices distinguish full (wrap bits differ) from empty (wrap bits equal).
    // A per-slot valid bit tracks occupancy for the pending-address probe.
    // ------------------------------------------------------------------------
    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [DEPTH-1:0]   r_slot_vld;
            logic [ADDR_W-1:0]  r_fifo_rw [DEPTH];
            logic [DATA_W-1:0]  r_fifo_dw [DEPTH];

            logic [c_IDX_W-1:0] w_wr_idx;
            logic [c_IDX_W-1:0] w_rd_idx;
            logic               w_full;
            logic               w_push;
            logic               w_pop;
            logic [DEPTH-1:0]   w_set_mask;
            logic [DEPTH-1:0]   w_clr_mask;
            logic               w_src_hit;

            assign w_wr_idx   = r_wr_ptr[c_IDX_W-1:0];
            assign w_rd_idx   = r_rd_ptr[c_IDX_W-1:0];
            assign w_empty[s] = (r_wr_ptr == r_rd_ptr);
            assign w_full     = (w_wr_idx == w_rd_idx) &&
                                (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]);

            // Ready never looks at valid or at a same-cycle pop
            assign w_ready[s] = !rst && !w_full;

            // Writes to register 0 complete the handshake but are dropped here
            assign w_push = w_in_valid[s] && w_ready[s] && (w_in_rw[s] != '0);
            assign w_pop  = w_grant[s];

            assign w_set_mask = w_push ? (DEPTH'(1) << w_wr_idx) : '0;
            assign w_clr_mask = w_pop  ? (DEPTH'(1) << w_rd_idx) : '0;

            assign w_head_rw[s] = r_fifo_rw[w_rd_idx];
            assign w_head_dw[s] = r_fifo_dw[w_rd_idx];

            // Pointer and occupancy bookkeeping
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr   <= '0;
                    r_rd_ptr   <= '0;
                    r_slot_vld <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                    end
                    r_slot_vld <= (r_slot_vld & ~w_clr_mask) | w_set_mask;
                end
            end

            // Entry storage; contents are qualified by r_slot_vld, so no reset
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_fifo_rw[w_wr_idx] <= w_in_rw[s];
                    r_fifo_dw[w_wr_idx] <= w_in_dw[s];
                end
            end

            // Any occupied slot of this source targeting the probed address
            always_comb begin
                w_src_hit = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_slot_vld[i] && (r_fifo_rw[i] == bus.chk_addr)) begin
                        w_src_hit = 1'b1;
                    end
                end
            end

            assign w_hit[s] = w_src_hit;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin: a lone non-empty source wins; on a tie the source that was
    // not granted last wins. ALU has priority when MEM was granted last.
    // ------------------------------------------------------------------------
    assign w_grant[c_ALU] = !w_empty[c_ALU] &&
                            (w_empty[c_MEM] || (r_last_grant == 1'(c_MEM)));
    assign w_grant[c_MEM] = !w_empty[c_MEM] && !w_grant[c_ALU];

    // Registered write port and grant history; rw/dw hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wr_en   <= 1'b0;
            r_rw         <= '0;
            r_dw         <= '0;
            r_last_grant <= 1'(c_MEM);
        end else if (|w_grant) begin
            r_rf_wr_en   <= 1'b1;
            r_rw         <= w_grant[c_ALU] ? w_head_rw[c_ALU] : w_head_rw[c_MEM];
            r_dw         <= w_grant[c_ALU] ? w_head_dw[c_ALU] : w_head_dw[c_MEM];
            r_last_grant <= w_grant[c_MEM];
        end else begin
            r_rf_wr_en   <= 1'b0;
        end
    end

    assign bus.rw       = r_rw;
    assign bus.dw       = r_dw;
    assign bus.rf_wr_en = r_rf_wr_en;

    // Register 0 is never written, so it is never reported as pending
    assign bus.chk_pending = (bus.chk_addr != '0) &&
                             ((|w_hit) || (r_rf_wr_en && (r_rw == bus.chk_addr)));

    assign bus.busy = !(&w_empty) || r_rf_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Self-checking bench for rf_write_arbiter: directed scenarios
//                plus randomized traffic against a queue-based reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic clk;
    logic rst;

    rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: per-source queues of pending writes plus the port state
    logic [ADDR_W-1:0] aq_rw [$];
    logic [DATA_W-1:0] aq_dw [$];
    logic [ADDR_W-1:0] mq_rw [$];
    logic [DATA_W-1:0] mq_dw [$];
    logic              m_en;
    logic [ADDR_W-1:0] m_rw;
    logic [DATA_W-1:0] m_dw;
    logic              m_last_mem;

    logic [ADDR_W-1:0] port_log [$];
    logic              a_acc_last;
    logic              m_acc_last;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check combinational outputs, advance model, check port
    task automatic tick();
        logic              a_rdy, m_rdy, a_acc, m_acc, pend, r;
        logic [ADDR_W-1:0] a_rw, mm_rw;
        logic [DATA_W-1:0] a_dw, mm_dw;
        logic              g_alu, g_mem;
        #1;
        r     = rst;
        a_rdy = !r && (aq_rw.size() < DEPTH);
        m_rdy = !r && (mq_rw.size() < DEPTH);
        check("alu_ready", 64'(bus.alu_ready), 64'(a_rdy));
        check("mem_ready", 64'(bus.mem_ready), 64'(m_rdy));
        pend = 1'b0;
        if (bus.chk_addr != '0) begin
            foreach (aq_rw[i]) if (aq_rw[i] == bus.chk_addr) pend = 1'b1;
            foreach (mq_rw[i]) if (mq_rw[i] == bus.chk_addr) pend = 1'b1;
            if (m_en && m_rw == bus.chk_addr) pend = 1'b1;
        end
        check("chk_pending", 64'(bus.chk_pending), 64'(pend));
        check("busy", 64'(bus.busy), 64'((aq_rw.size() != 0) || (mq_rw.size() != 0) || m_en));
        a_acc = bus.alu_valid && a_rdy;
        m_acc = bus.mem_valid && m_rdy;
        a_rw  = bus.alu_rw;  a_dw  = bus.alu_dw;
        mm_rw = bus.mem_rw;  mm_dw = bus.mem_dw;
        a_acc_last = a_acc;
        m_acc_last = m_acc;
        @(posedge clk);
        if (r) begin
            aq_rw.delete(); aq_dw.delete(); mq_rw.delete(); mq_dw.delete();
            m_en = 1'b0; m_rw = '0; m_dw = '0; m_last_mem = 1'b1;
        end else begin
            g_alu = (aq_rw.size() != 0) && ((mq_rw.size() == 0) || m_last_mem);
            g_mem = (mq_rw.size() != 0) && !g_alu;
            if (g_alu) begin
                m_rw = aq_rw.pop_front(); m_dw = aq_dw.pop_front();
                m_en = 1'b1; m_last_mem = 1'b0;
            end else if (g_mem) begin
                m_rw = mq_rw.pop_front(); m_dw = mq_dw.pop_front();
                m_en = 1'b1; m_last_mem = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            if (a_acc && a_rw != '0) begin aq_rw.push_back(a_rw); aq_dw.push_back(a_dw); end
            if (m_acc && mm_rw != '0) begin mq_rw.push_back(mm_rw); mq_dw.push_back(mm_dw); end
        end
        #1;
        check("rf_wr_en", 64'(bus.rf_wr_en), 64'(m_en));
        check("rw", 64'(bus.rw), 64'(m_rw));
        check("dw", 64'(bus.dw), 64'(m_dw));
        if (bus.rf_wr_en) port_log.push_back(bus.rw);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rw = '0; bus.alu_dw = '0;
        bus.mem_valid = 1'b0; bus.mem_rw = '0; bus.mem_dw = '0;
    endtask

    initial begin
        int tie_exp [4];
        int acc_cnt;
        int bound;
        n_checks = 0; n_pass = 0;
        m_en = 1'b0; m_rw = '0; m_dw = '0; m_last_mem = 1'b1;
        a_acc_last = 1'b0; m_acc_last = 1'b0;
        rst = 1'b1;
        idle_inputs();
        bus.chk_addr = '0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single ALU write: port shows r20 for exactly one cycle
        bus.chk_addr = 5'd20;
        bus.alu_valid = 1'b1; bus.alu_rw = 5'd20; bus.alu_dw = 32'hF5;
        tick();
        idle_inputs();
        tick();
        check("single_en", 64'(bus.rf_wr_en), 64'd1);
        check("single_rw", 64'(bus.rw), 64'd20);
        check("single_dw", 64'(bus.dw), 64'hF5);
        tick();
        check("single_en_drop", 64'(bus.rf_wr_en), 64'd0);
        tick();

        // Register 0 write is accepted but never reaches the port
        bus.chk_addr = '0;
        bus.alu_valid = 1'b1; bus.alu_rw = '0; bus.alu_dw = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        tick(); tick();

        // Tie after reset: expected port order 1, 3, 2, 4
        rst = 1'b1; tick(); rst = 1'b0;
        port_log.delete();
        bus.alu_valid = 1'b1; bus.alu_rw = 5'd1; bus.alu_dw = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_rw = 5'd3; bus.mem_dw = 32'h33;
        tick();
        bus.alu_rw = 5'd2; bus.alu_dw = 32'h22;
        bus.mem_rw = 5'd4; bus.mem_dw = 32'h44;
        tick();
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();
        tie_exp = '{1, 3, 2, 4};
        check("tie_count", 64'(port_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < port_log.size()) check("tie_order", 64'(port_log[i]), 64'(tie_exp[i]));
        end

        // Backpressure: ALU pushes DEPTH+2 writes while MEM contends
        acc_cnt = 0;
        bound   = 0;
        bus.mem_valid = 1'b1;
        while (acc_cnt < DEPTH + 2 && bound < 40) begin
            bus.alu_valid = 1'b1;
            bus.alu_rw = 5'(8 + acc_cnt); bus.alu_dw = 32'hA000 + 32'(acc_cnt);
            bus.mem_rw = 5'(16 + (bound % 4)); bus.mem_dw = 32'hB000 + 32'(bound);
            tick();
            if (a_acc_last) acc_cnt++;
            bound++;
        end
        check("bp_accepted", 64'(acc_cnt), 64'(DEPTH + 2));
        idle_inputs();
        for (int i = 0; i < 8; i++) tick();

        // Hazard: r17 queued behind other MEM writes while ALU contends
        bus.chk_addr = 5'd17;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rw = 5'(24 + i); bus.alu_dw = 32'(i);
            bus.mem_valid = 1'b1; bus.mem_rw = (i == 2) ? 5'd17 : 5'(12 + i);
            bus.mem_dw = 32'hC0 + 32'(i);
            bound = 0;
            do begin tick(); bound++; end while (!m_acc_last && bound < 10);
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) tick();

        // Reset mid-operation with three writes queued
        bus.chk_addr = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_rw = 5'd9;  bus.alu_dw = 32'h9;
        bus.mem_valid = 1'b1; bus.mem_rw = 5'd10; bus.mem_dw = 32'hA;
        tick();
        bus.alu_rw = 5'd11; bus.alu_dw = 32'hB; bus.mem_valid = 1'b0;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_en", 64'(bus.rf_wr_en), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        bus.alu_valid = 1'b1; bus.alu_rw = 5'd9; bus.alu_dw = 32'h99;
        tick();
        idle_inputs();
        tick();
        check("post_rst_en", 64'(bus.rf_wr_en), 64'd1);
        check("post_rst_dw", 64'(bus.dw), 64'h99);
        tick();

        // Randomized traffic with protocol-compliant holding and rare resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!bus.alu_valid || a_acc_last) begin
                bus.alu_valid = ($urandom_range(0, 99) < 60);
                bus.alu_rw = 5'($urandom_range(0, 7));
                bus.alu_dw = $urandom;
            end
            if (!bus.mem_valid || m_acc_last) begin
                bus.mem_valid = ($urandom_range(0, 99) < 55);
                bus.mem_rw = 5'($urandom_range(0, 7));
                bus.mem_dw = $urandom;
            end
            bus.chk_addr = 5'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
